// File: rtl/coherence_bus_ctrl_if.sv
// Signal bundle between the per-core caches, the coherence bus controller and the single RAM port.
// Per-core signals are packed [core] vectors; the controller takes the slave view.
interface coherence_bus_ctrl_if;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0][31:0] iload;
    logic [1:0]       iwait;
    logic [1:0]       dREN;
    logic [1:0]       dWEN;
    logic [1:0][31:0] daddr;
    logic [1:0][31:0] dstore;
    logic [1:0][31:0] dload;
    logic [1:0]       dwait;
    logic [1:0]       cctrans;
    logic [1:0]       ccwrite;
    logic [1:0]       ccwait;
    logic [1:0]       ccinv;
    logic [1:0][31:0] ccsnoopaddr;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        output iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
        input  iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
               ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Dual-core shared-memory bus controller: arbitrates icache/dcache traffic onto one RAM port.
// Define COHERENCE_SNOOP_EN to snoop dcache reads in the peer dcache with cache-to-cache transfer.
module coherence_bus_ctrl #(
    parameter int CPUS          = 2,
    parameter int RAM_ERR_RETRY = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    coherence_bus_ctrl_if.slave bus
);

    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;
    localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;
    // After reset the highest core counts as last granted, so core 0 wins the first tie.
    localparam logic        LAST_CORE  = 1'(CPUS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
`ifdef COHERENCE_SNOOP_EN
        ST_SNOOP  = 3'd2,
        ST_C2C    = 3'd3,
`endif
        ST_MEMRD  = 3'd4,
        ST_MEMWR  = 3'd5,
        ST_IFETCH = 3'd6
    } state_e;

    state_e state_r;
    state_e state_nxt_s;
    logic   gnt_r;
    logic   gnt_nxt_s;
    logic   peer_s;
    logic   any_req_s;
    logic   err_done_s;
    logic   done_s;
    logic   req_held_s;
    logic   complete_s;
    logic   unused_s;

    // Round-robin pick between the two cores of one request class.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[0]) begin
            pick = 1'b0;
        end else begin
            pick = 1'b1;
        end
        return pick;
    endfunction

    assign peer_s     = ~gnt_r;
    assign any_req_s  = |{bus.iREN, bus.dREN, bus.dWEN};
    assign err_done_s = (RAM_ERR_RETRY == 0) && (bus.ramstate == RAM_ERROR);
    assign done_s     = (bus.ramstate == RAM_ACCESS) || err_done_s;
    assign complete_s = req_held_s && done_s;
    assign unused_s   = ^{bus.cctrans, bus.ccwrite};

    // Whether the granted requester still holds the request that owns the current state.
    always_comb begin
        req_held_s = 1'b0;
        case (state_r)
`ifdef COHERENCE_SNOOP_EN
            ST_SNOOP:  req_held_s = bus.dREN[gnt_r];
            ST_C2C:    req_held_s = bus.dREN[gnt_r];
`endif
            ST_MEMRD:  req_held_s = bus.dREN[gnt_r];
            ST_MEMWR:  req_held_s = bus.dWEN[gnt_r];
            ST_IFETCH: req_held_s = bus.iREN[gnt_r];
            default:   req_held_s = 1'b0;
        endcase
    end

    // State and grant register; gnt_r doubles as the last-granted core.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            gnt_r   <= LAST_CORE;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
        end
    end

    // Next-state and arbitration: writes before reads before fetches.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (|bus.dWEN) begin
                    gnt_nxt_s   = rr_pick(bus.dWEN, gnt_r);
                    state_nxt_s = ST_MEMWR;
                end else if (|bus.dREN) begin
                    gnt_nxt_s   = rr_pick(bus.dREN, gnt_r);
`ifdef COHERENCE_SNOOP_EN
                    state_nxt_s = ST_SNOOP;
`else
                    state_nxt_s = ST_MEMRD;
`endif
                end else if (|bus.iREN) begin
                    gnt_nxt_s   = rr_pick(bus.iREN, gnt_r);
                    state_nxt_s = ST_IFETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef COHERENCE_SNOOP_EN
            ST_SNOOP: begin
                if (!req_held_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.ccwrite[peer_s]) begin
                    state_nxt_s = ST_C2C;
                end else begin
                    state_nxt_s = ST_MEMRD;
                end
            end
            ST_C2C: begin
                if (!req_held_s || done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
`endif
            ST_MEMRD, ST_MEMWR, ST_IFETCH: begin
                if (!req_held_s || done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and grant; read data passes straight through during the access.
    always_comb begin
        bus.iload       = '0;
        bus.iwait       = 2'b11;
        bus.dload       = '0;
        bus.dwait       = 2'b11;
        bus.ccwait      = 2'b00;
        bus.ccinv       = 2'b00;
        bus.ccsnoopaddr = '0;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = 32'h0000_0000;
        bus.ramstore    = 32'h0000_0000;
        case (state_r)
`ifdef COHERENCE_SNOOP_EN
            ST_SNOOP: begin
                bus.ccwait[peer_s]      = 1'b1;
                bus.ccsnoopaddr[peer_s] = bus.daddr[gnt_r];
                bus.ccinv[peer_s]       = bus.ccwrite[gnt_r];
            end
            ST_C2C: begin
                bus.ccwait[peer_s]      = 1'b1;
                bus.ccsnoopaddr[peer_s] = bus.daddr[gnt_r];
                bus.ccinv[peer_s]       = bus.ccwrite[gnt_r];
                // Peer data goes to the requester and is written back to RAM in the same access.
                bus.ramWEN              = 1'b1;
                bus.ramaddr             = bus.daddr[gnt_r];
                bus.ramstore            = bus.dstore[peer_s];
                bus.dload[gnt_r]        = err_done_s ? ERR_WORD : bus.dstore[peer_s];
                bus.dwait[gnt_r]        = ~complete_s;
            end
`endif
            ST_MEMRD: begin
                bus.ramREN       = 1'b1;
                bus.ramaddr      = bus.daddr[gnt_r];
                bus.dload[gnt_r] = err_done_s ? ERR_WORD : bus.ramload;
                bus.dwait[gnt_r] = ~complete_s;
            end
            ST_MEMWR: begin
                bus.ramWEN       = 1'b1;
                bus.ramaddr      = bus.daddr[gnt_r];
                bus.ramstore     = bus.dstore[gnt_r];
                bus.dwait[gnt_r] = ~complete_s;
            end
            ST_IFETCH: begin
                bus.ramREN       = 1'b1;
                bus.ramaddr      = bus.iaddr[gnt_r];
                bus.iload[gnt_r] = err_done_s ? ERR_WORD : bus.ramload;
                bus.iwait[gnt_r] = ~complete_s;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: one retrying instance plus a non-retrying twin fed the
// same inputs, compared against hand-computed values cycle by cycle.
module tb_coherence_bus_ctrl;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] want_addr;
    logic [31:0] want_wait;

    coherence_bus_ctrl_if bus ();
    coherence_bus_ctrl_if bus0 ();

    coherence_bus_ctrl #(.CPUS(2), .RAM_ERR_RETRY(1)) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    coherence_bus_ctrl #(.CPUS(2), .RAM_ERR_RETRY(0)) u_dut0 (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus0)
    );

    always #5 CLK = ~CLK;

    assign bus0.iREN     = bus.iREN;
    assign bus0.iaddr    = bus.iaddr;
    assign bus0.dREN     = bus.dREN;
    assign bus0.dWEN     = bus.dWEN;
    assign bus0.daddr    = bus.daddr;
    assign bus0.dstore   = bus.dstore;
    assign bus0.cctrans  = bus.cctrans;
    assign bus0.ccwrite  = bus.ccwrite;
    assign bus0.ramload  = bus.ramload;
    assign bus0.ramstate = bus.ramstate;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST         = 1'b0;
        bus.iREN     = 2'b00;
        bus.dREN     = 2'b00;
        bus.dWEN     = 2'b00;
        bus.cctrans  = 2'b00;
        bus.ccwrite  = 2'b00;
        bus.iaddr    = '0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = 32'h0;
        bus.ramstate = RS_FREE;
        tick();
        tick();

        // reset values
        chk("rst_iwait",   32'(bus.iwait), 32'h3);
        chk("rst_dwait",   32'(bus.dwait), 32'h3);
        chk("rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'h0);
        chk("rst_ccwait",  32'(bus.ccwait), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        chk("rst_dload0",  bus.dload[0], 32'h0);
        nRST = 1'b1;

        // icache fetch, RAM answers at once: completion on cycle 3
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h40;
        bus.ramstate = RS_ACCESS;
        bus.ramload  = 32'h8C010004;
        #1;
        chk("if_c1_iwait", 32'(bus.iwait), 32'h3);
        tick();
        chk("if_c2_iwait", 32'(bus.iwait), 32'h3);
        chk("if_c2_ramREN", 32'(bus.ramREN), 32'h0);
        tick();
        chk("if_c3_iwait", 32'(bus.iwait), 32'h2);
        chk("if_c3_ramREN", 32'(bus.ramREN), 32'h1);
        chk("if_c3_ramaddr", bus.ramaddr, 32'h40);
        chk("if_c3_iload0", bus.iload[0], 32'h8C010004);
        bus.iREN[0] = 1'b0;
        tick();
        chk("if_c4_iwait", 32'(bus.iwait), 32'h3);
        chk("if_c4_ramREN", 32'(bus.ramREN), 32'h0);

        // dWEN[1] beats dREN[0]; then the read is served
        bus.dWEN[1]   = 1'b1;
        bus.daddr[1]  = 32'h500;
        bus.dstore[1] = 32'h12345678;
        bus.dREN[0]   = 1'b1;
        bus.daddr[0]  = 32'h600;
        bus.ramload   = 32'hA5A50600;
        tick();
        tick();
        chk("wr_ramWEN", 32'(bus.ramWEN), 32'h1);
        chk("wr_ramREN", 32'(bus.ramREN), 32'h0);
        chk("wr_ramaddr", bus.ramaddr, 32'h500);
        chk("wr_ramstore", bus.ramstore, 32'h12345678);
        chk("wr_dwait", 32'(bus.dwait), 32'h1);
        bus.dWEN[1] = 1'b0;
        tick();
        chk("wr_idle_dwait", 32'(bus.dwait), 32'h3);
        tick();
`ifdef COHERENCE_SNOOP_EN
        tick();
        chk("rd_snoop_ccwait", 32'(bus.ccwait), 32'h2);
        chk("rd_snoop_addr", bus.ccsnoopaddr[1], 32'h600);
        chk("rd_snoop_ramREN", 32'(bus.ramREN), 32'h0);
`endif
        tick();
        chk("rd_ramREN", 32'(bus.ramREN), 32'h1);
        chk("rd_ramaddr", bus.ramaddr, 32'h600);
        chk("rd_dload0", bus.dload[0], 32'hA5A50600);
        chk("rd_dwait", 32'(bus.dwait), 32'h2);
        bus.dREN[0] = 1'b0;
        tick();

        // dREN[0] with iREN[1]: dcache first, RAM busy for one cycle
        bus.dREN[0]  = 1'b1;
        bus.daddr[0] = 32'h700;
        bus.iREN[1]  = 1'b1;
        bus.iaddr[1] = 32'h800;
        bus.ramstate = RS_BUSY;
        tick();
        chk("mix_arb_ramREN", 32'(bus.ramREN), 32'h0);
`ifdef COHERENCE_SNOOP_EN
        tick();
        chk("mix_snoop_ramREN", 32'(bus.ramREN), 32'h0);
`endif
        tick();
        chk("mix_busy_ramaddr", bus.ramaddr, 32'h700);
        chk("mix_busy_dwait", 32'(bus.dwait), 32'h3);
        chk("mix_busy_iwait", 32'(bus.iwait), 32'h3);
        bus.ramstate = RS_ACCESS;
        #1;
        chk("mix_acc_dwait", 32'(bus.dwait), 32'h2);
        chk("mix_acc_ramaddr", bus.ramaddr, 32'h700);
        bus.dREN[0] = 1'b0;
        tick();
        chk("mix_idle_ramREN", 32'(bus.ramREN), 32'h0);
        tick();
        tick();
        chk("mix_if_ramaddr", bus.ramaddr, 32'h800);
        chk("mix_if_iwait", 32'(bus.iwait), 32'h1);
        bus.iREN[1] = 1'b0;
        tick();

        // read-exclusive from core 1 with a hit in core 0
        bus.dREN[1]    = 1'b1;
        bus.daddr[1]   = 32'h3100;
        bus.ccwrite[1] = 1'b1;
        bus.cctrans[1] = 1'b1;
        bus.ccwrite[0] = 1'b1;
        bus.dstore[0]  = 32'hDEADBEEF;
        tick();
`ifdef COHERENCE_SNOOP_EN
        tick();
        chk("c2c_snoop_ccwait", 32'(bus.ccwait), 32'h1);
        chk("c2c_snoop_ccinv", 32'(bus.ccinv), 32'h1);
        chk("c2c_snoop_addr", bus.ccsnoopaddr[0], 32'h3100);
        tick();
        chk("c2c_ramWEN", 32'(bus.ramWEN), 32'h1);
        chk("c2c_ramREN", 32'(bus.ramREN), 32'h0);
        chk("c2c_ramaddr", bus.ramaddr, 32'h3100);
        chk("c2c_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("c2c_dload1", bus.dload[1], 32'hDEADBEEF);
        chk("c2c_dwait", 32'(bus.dwait), 32'h1);
        chk("c2c_ccwait", 32'(bus.ccwait), 32'h1);
`else
        tick();
        chk("nosnp_ramREN", 32'(bus.ramREN), 32'h1);
        chk("nosnp_ramaddr", bus.ramaddr, 32'h3100);
        chk("nosnp_ccwait", 32'(bus.ccwait), 32'h0);
        chk("nosnp_ccaddr", bus.ccsnoopaddr[0], 32'h0);
        chk("nosnp_dwait", 32'(bus.dwait), 32'h1);
`endif
        bus.dREN[1]    = 1'b0;
        bus.ccwrite    = 2'b00;
        bus.cctrans    = 2'b00;
        tick();
        chk("c2c_idle_ccwait", 32'(bus.ccwait), 32'h0);
        chk("c2c_idle_ramWEN", 32'(bus.ramWEN), 32'h0);

        // request dropped mid-access: no completion pulse
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'h900;
        bus.ramstate = RS_BUSY;
        tick();
        tick();
        chk("drop_ramREN", 32'(bus.ramREN), 32'h1);
        bus.iREN[0]  = 1'b0;
        bus.ramstate = RS_ACCESS;
        #1;
        chk("drop_iwait", 32'(bus.iwait), 32'h3);
        tick();
        chk("drop_idle_ramREN", 32'(bus.ramREN), 32'h0);

        // BUSY x3, ERROR, ACCESS: retry instance waits, non-retry twin completes at ERROR
        bus.iREN[0]  = 1'b1;
        bus.iaddr[0] = 32'hA00;
        bus.ramload  = 32'h11112222;
        bus.ramstate = RS_BUSY;
        tick();
        for (int b = 0; b < 3; b++) begin
            tick();
            chk($sformatf("err_busy%0d_ramREN", b), 32'(bus.ramREN), 32'h1);
            chk($sformatf("err_busy%0d_iwait", b), 32'(bus.iwait), 32'h3);
        end
        bus.ramstate = RS_ERROR;
        #1;
        chk("err_retry_ramREN", 32'(bus.ramREN), 32'h1);
        chk("err_retry_iwait", 32'(bus.iwait), 32'h3);
        chk("err_noretry_iwait", 32'(bus0.iwait), 32'h2);
        chk("err_noretry_iload", bus0.iload[0], 32'hBAD1BAD1);
        tick();
        bus.ramstate = RS_ACCESS;
        #1;
        chk("err_retry_done_iwait", 32'(bus.iwait), 32'h2);
        chk("err_retry_done_iload", bus.iload[0], 32'h11112222);
        chk("err_noretry_after_ramREN", 32'(bus0.ramREN), 32'h0);
        chk("err_noretry_after_iwait", 32'(bus0.iwait), 32'h3);
        bus.iREN[0] = 1'b0;
        tick();
        chk("err_idle_ramREN", 32'(bus.ramREN), 32'h0);

        // nRST during the access (C2C when snooping) from core 0
        bus.dREN[0]    = 1'b1;
        bus.daddr[0]   = 32'h4400;
        bus.ccwrite[0] = 1'b1;
        bus.ccwrite[1] = 1'b1;
        bus.dstore[1]  = 32'hCAFEF00D;
        bus.ramstate   = RS_BUSY;
        tick();
`ifdef COHERENCE_SNOOP_EN
        tick();
`endif
        tick();
        chk("rstx_pre_strobe", 32'(bus.ramREN | bus.ramWEN), 32'h1);
`ifdef COHERENCE_SNOOP_EN
        chk("rstx_pre_ccwait", 32'(bus.ccwait), 32'h2);
`endif
        nRST = 1'b0;
        #1;
        chk("rstx_strobe", 32'(bus.ramREN | bus.ramWEN), 32'h0);
        chk("rstx_ccwait", 32'(bus.ccwait), 32'h0);
        chk("rstx_dwait", 32'(bus.dwait), 32'h3);
        bus.dREN     = 2'b00;
        bus.ccwrite  = 2'b00;
        bus.ramstate = RS_ACCESS;
        tick();
        nRST = 1'b1;

        // both icaches held: grants alternate, core 0 first after reset
        bus.iREN     = 2'b11;
        bus.iaddr[0] = 32'h100;
        bus.iaddr[1] = 32'h200;
        for (int k = 0; k < 4; k++) begin
            want_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
            want_wait = (k % 2 == 0) ? 32'h2 : 32'h1;
            tick();
            tick();
            chk($sformatf("tie%0d_ramaddr", k), bus.ramaddr, want_addr);
            chk($sformatf("tie%0d_iwait", k), 32'(bus.iwait), want_wait);
            tick();
        end
        bus.iREN = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
